// File: rtl/census_transform_param.sv
// census_transform_param: streaming census transform over a WIN_H x WIN_W
// window. Pixels arrive in raster order and pass through cascaded line
// buffers into a window shift register. Two register stages then compare
// each neighbour against the centre and pack the result. Flags are derived
// from output-side position counters. A flush phase injects zero pixels
// after the last pixel of a frame so that the tail of the frame drains out.
module census_transform_param #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIX_W        = 8,
  parameter int WIN_W        = 9,
  parameter int WIN_H        = 7,
  parameter int DESC_W       = WIN_W * WIN_H - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PIX_W-1:0]  data_in,
  input  logic              sof_in,
  input  logic              eol_in,
  output logic              in_ready,
  output logic [DESC_W-1:0] data_out,
  output logic              valid_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              border_out
);

  localparam int R       = WIN_H / 2;
  localparam int C       = WIN_W / 2;
  localparam int NLB     = WIN_H - 1;
  localparam int CIDX    = R * WIN_W + C;
  localparam int XW      = $clog2(IMAGE_WIDTH);
  localparam int YW      = $clog2(IMAGE_HEIGHT);
  localparam int FLUSH_N = R * IMAGE_WIDTH + C + 2;
  localparam int FW      = $clog2(FLUSH_N + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMAGE_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_N);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state, stateNext;
  logic [XW-1:0]   inX, inXNext, curX;
  logic [YW-1:0]   inY, inYNext, curY;
  logic [FW-1:0]   flushCnt, flushNext;
  logic            advance, accept;
  logic [PIX_W:0]  newPix;
  logic [XW-1:0]   wrAddr, rdAddr;

  logic [PIX_W:0]  lineMem [NLB][IMAGE_WIDTH];
  logic [PIX_W:0]  lbOut   [NLB];
  logic [PIX_W:0]  lbIn    [NLB];
  logic [PIX_W:0]  rowIn   [WIN_H];
  logic [PIX_W:0]  win     [WIN_H][WIN_W];

  logic [DESC_W-1:0] cmpNext, cmp_p1;
  logic              centerTag, lastPos_p1, border_p1;
  logic              vldNext, vld_p1, sof_p1;
  logic [XW-1:0]     oxNext, ox_p1;
  logic [YW-1:0]     oyNext, oy_p1;
  logic              sofFlag, eolFlag;

  // eol_in carries no information the input counters do not already have.
  logic unusedEol;
  assign unusedEol = eol_in;

  // Unsigned neighbour test: descriptor bit is set when the centre is larger.
  function automatic logic pixGt(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a > b;
  endfunction

  // Border band: positions whose full window would leave the image.
  function automatic logic isBorder(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < C) || (int'(x) >= IMAGE_WIDTH - C) ||
           (int'(y) < R) || (int'(y) >= IMAGE_HEIGHT - R);
  endfunction

  assign in_ready = (state != FLUSH);
  // Reading one address ahead of the write gives a total delay of exactly
  // one line through the RAM plus its output register.
  assign rdAddr   = (wrAddr == X_LAST) ? '0 : wrAddr + XW'(1);

  // Next-state, input acceptance, input counters and flush countdown.
  always_comb begin
    stateNext = state;
    inXNext   = inX;
    inYNext   = inY;
    flushNext = flushCnt;
    accept    = 1'b0;
    advance   = 1'b0;
    newPix    = '0;
    curX      = sof_in ? '0 : inX;
    curY      = sof_in ? '0 : inY;
    case (state)
      IDLE: begin
        if (en && sof_in) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (en) accept = 1'b1;
      end
      FLUSH: begin
        if (en) begin
          advance   = 1'b1;
          flushNext = flushCnt - FW'(1);
          if (flushCnt == FW'(1)) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (accept) begin
      advance = 1'b1;
      newPix  = {sof_in, data_in};
      if (curX == X_LAST) begin
        inXNext = '0;
        inYNext = (curY == Y_LAST) ? '0 : curY + YW'(1);
      end else begin
        inXNext = curX + XW'(1);
        inYNext = curY;
      end
      if ((curX == X_LAST) && (curY == Y_LAST)) begin
        stateNext = FLUSH;
        flushNext = FLUSH_LOAD;
      end
    end
  end

  // Control registers: FSM state, input counters, flush counter, RAM address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      inX      <= '0;
      inY      <= '0;
      flushCnt <= '0;
      wrAddr   <= '0;
    end else begin
      state    <= stateNext;
      inX      <= inXNext;
      inY      <= inYNext;
      flushCnt <= flushNext;
      if (advance) wrAddr <= rdAddr;
    end
  end

  // Line-buffer cascade and window column feed; row WIN_H-1 is the newest line.
  always_comb begin
    lbIn[0] = newPix;
    for (int k = 1; k < NLB; k++) lbIn[k] = lbOut[k-1];
    rowIn[WIN_H-1] = newPix;
    for (int r = 0; r < WIN_H - 1; r++) rowIn[r] = lbOut[WIN_H-2-r];
  end

  // Line-buffer RAMs: simple dual port, registered read, no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NLB; k++) begin
        lineMem[k][wrAddr] <= lbIn[k];
        lbOut[k]           <= lineMem[k][rdAddr];
      end
    end
  end

  // Window shift registers; column 0 holds the oldest pixel of each row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_H; r++)
        for (int c = 0; c < WIN_W; c++) win[r][c] <= '0;
    end else if (advance) begin
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W - 1; c++) win[r][c] <= win[r][c+1];
        win[r][WIN_W-1] <= rowIn[r];
      end
    end
  end

  // Neighbour comparisons in raster order with the centre position skipped.
  for (genvar r = 0; r < WIN_H; r++) begin : g_row
    for (genvar c = 0; c < WIN_W; c++) begin : g_col
      if (r * WIN_W + c < CIDX) begin : g_lo
        assign cmpNext[r*WIN_W+c] = pixGt(win[R][C][PIX_W-1:0], win[r][c][PIX_W-1:0]);
      end else if (r * WIN_W + c > CIDX) begin : g_hi
        assign cmpNext[r*WIN_W+c-1] = pixGt(win[R][C][PIX_W-1:0], win[r][c][PIX_W-1:0]);
      end
    end
  end

  // Output position tracking: a tagged centre restarts the frame at (0,0).
  always_comb begin
    centerTag  = win[R][C][PIX_W];
    lastPos_p1 = (ox_p1 == X_LAST) && (oy_p1 == Y_LAST);
    oxNext     = ox_p1;
    oyNext     = oy_p1;
    vldNext    = 1'b0;
    if (centerTag) begin
      oxNext  = '0;
      oyNext  = '0;
      vldNext = 1'b1;
    end else if (vld_p1 && !lastPos_p1) begin
      vldNext = 1'b1;
      if (ox_p1 == X_LAST) begin
        oxNext = '0;
        oyNext = oy_p1 + YW'(1);
      end else begin
        oxNext = ox_p1 + XW'(1);
      end
    end
  end

  assign border_p1 = isBorder(ox_p1, oy_p1);

  // ---- stage p1: compare (control part) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      ox_p1  <= '0;
      oy_p1  <= '0;
    end else if (advance) begin
      vld_p1 <= vldNext;
      sof_p1 <= centerTag;
      ox_p1  <= oxNext;
      oy_p1  <= oyNext;
    end
  end

  // ---- stage p1: compare (data part) ----
  always_ff @(posedge clk) begin
    if (advance) cmp_p1 <= cmpNext;
  end

  // ---- stage p2: pack, border masking and output flags ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      sofFlag    <= 1'b0;
      eolFlag    <= 1'b0;
      border_out <= 1'b0;
    end else if (advance) begin
      data_out   <= border_p1 ? '0 : cmp_p1;
      valid_out  <= vld_p1;
      sofFlag    <= sof_p1;
      eolFlag    <= (ox_p1 == X_LAST);
      border_out <= vld_p1 && border_p1;
    end else begin
      valid_out  <= 1'b0;
    end
  end

  assign sof_out = valid_out & sofFlag;
  assign eol_out = valid_out & eolFlag;

endmodule

// File: tb/tb_census_transform_param.sv
// tb_census_transform_param: directed frames on an 8x6 image with a 3x3
// window (constant, ramp, ramp with gated enable, single dark pixel,
// mid-frame resync, reset during flush), expected descriptors hand-derived.
module tb_census_transform_param;

  localparam int IW = 8;
  localparam int IH = 6;
  localparam int PW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] data_in = '0;
  logic          sof_in = 1'b0;
  logic          eol_in = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          sof_out;
  logic          eol_out;
  logic          border_out;

  census_transform_param #(
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH),
    .PIX_W       (PW),
    .WIN_W       (3),
    .WIN_H       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .sof_in    (sof_in),
    .eol_in    (eol_in),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sof_out   (sof_out),
    .eol_out   (eol_out),
    .border_out(border_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       b;
    int         t;
  } rec_t;

  rec_t q[$];
  rec_t mon;
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  int   sofCyc  = 0;
  logic enQ     = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    enQ <= en;
  end

  always @(negedge clk) begin
    if (valid_out) begin
      mon.d = data_out;
      mon.s = sof_out;
      mon.e = eol_out;
      mon.b = border_out;
      mon.t = cyc;
      q.push_back(mon);
      checkVal("valid_without_en", {31'b0, enQ}, 32'd1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pixVal(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'd50;
      1:       return 8'(x + 8 * y);
      default: return (x == 3 && y == 2) ? 8'd5 : 8'd60;
    endcase
  endfunction

  function automatic logic isBord(input int x, input int y);
    return (x < 1) || (x >= 7) || (y < 1) || (y >= 5);
  endfunction

  // Hand-derived descriptors: ramp interior has the four earlier raster
  // neighbours smaller; dark pixel at (3,2) sets the bit facing it.
  function automatic logic [7:0] expData(input int mode, input int x, input int y);
    if (isBord(x, y)) return 8'h00;
    case (mode)
      0: return 8'h00;
      1: return 8'h0F;
      default: begin
        if (x == 2 && y == 1) return 8'h80;
        if (x == 3 && y == 1) return 8'h40;
        if (x == 4 && y == 1) return 8'h20;
        if (x == 2 && y == 2) return 8'h10;
        if (x == 4 && y == 2) return 8'h08;
        if (x == 2 && y == 3) return 8'h04;
        if (x == 3 && y == 3) return 8'h02;
        if (x == 4 && y == 3) return 8'h01;
        return 8'h00;
      end
    endcase
  endfunction

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic l);
    @(negedge clk);
    data_in = d;
    sof_in  = s;
    en      = e;
    eol_in  = l;
  endtask

  task automatic runFrame(input int mode, input bit toggle, input int resyncAt, input int abortAt);
    int   cnt;
    int   nb;
    int   x;
    int   y;
    rec_t r;
    q.delete();
    for (int i = 0; i < resyncAt; i++) begin
      if (toggle) drive(8'hAA, 1'b0, 1'b0, 1'b0);
      drive(pixVal(mode, i % IW, i / IW), i == 0, 1'b1, (i % IW) == IW - 1);
    end
    for (int i = 0; i < IW * IH; i++) begin
      if (toggle) drive(8'hAA, 1'b0, 1'b0, 1'b0);
      drive(pixVal(mode, i % IW, i / IW), i == 0, 1'b1, (i % IW) == IW - 1);
      if (i == 0) sofCyc = cyc + 1;
    end
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (abortAt > 0 && cnt == abortAt) begin
        checkVal("pre_reset_data", data_out, 32'h0F);
        checkVal("pre_reset_valid", valid_out, 32'd1);
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        checkVal("rst_data_out", data_out, 32'd0);
        checkVal("rst_flags", {valid_out, sof_out, eol_out, border_out}, 32'd0);
        checkVal("rst_in_ready", in_ready, 32'd1);
        rst_n = 1'b1;
        return;
      end
      en      = (toggle && (k % 2 == 0)) ? 1'b0 : 1'b1;
      data_in = '0;
      sof_in  = 1'b0;
      eol_in  = 1'b0;
      if (en) cnt++;
    end
    checkVal($sformatf("m%0d flush_cycles", mode), cnt, 32'd11);
    checkVal($sformatf("m%0d ready_after_flush", mode), in_ready, 32'd1);
    repeat (3) drive(8'h33, 1'b0, 1'b1, 1'b0);
    checkVal($sformatf("m%0d out_count", mode), q.size(), IW * IH + resyncAt);
    if (resyncAt > 0 && q.size() > 0) checkVal("old_frame_sof", {31'b0, q[0].s}, 32'd1);
    nb = 0;
    for (int i = 0; i < IW * IH; i++) begin
      if (resyncAt + i < q.size()) begin
        r = q[resyncAt + i];
        x = i % IW;
        y = i / IW;
        checkVal($sformatf("m%0d px%0d data", mode, i), r.d, expData(mode, x, y));
        checkVal($sformatf("m%0d px%0d sof/eol/border", mode, i), {r.s, r.e, r.b},
                 {29'b0, i == 0, x == IW - 1, isBord(x, y)});
        if (r.b) nb++;
      end
    end
    checkVal($sformatf("m%0d border_count", mode), nb, 32'd24);
    if (!toggle && q.size() > resyncAt)
      checkVal($sformatf("m%0d latency", mode), q[resyncAt].t - sofCyc, 32'd11);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("reset_data_out", data_out, 32'd0);
    checkVal("reset_valid", valid_out, 32'd0);
    checkVal("reset_sof", sof_out, 32'd0);
    checkVal("reset_eol", eol_out, 32'd0);
    checkVal("reset_border", border_out, 32'd0);
    checkVal("reset_in_ready", in_ready, 32'd1);
    rst_n = 1'b1;

    drive(8'h11, 1'b0, 1'b1, 1'b0);
    drive(8'h22, 1'b0, 1'b1, 1'b0);

    runFrame(0, 1'b0, 0, 0);
    runFrame(1, 1'b0, 0, 0);
    runFrame(1, 1'b1, 0, 0);
    runFrame(2, 1'b0, 0, 0);
    runFrame(1, 1'b0, 20, 0);
    runFrame(1, 1'b0, 0, 2);

    q.delete();
    repeat (5) drive(8'h77, 1'b0, 1'b1, 1'b0);
    checkVal("no_output_without_sof", q.size(), 32'd0);
    checkVal("idle_in_ready", in_ready, 32'd1);
    runFrame(0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
